// File: rtl/pwm_bank_if.sv
// Configuration write bus for pwm_bank: timebase shadows and per-channel duty shadows.
interface pwm_bank_if #(
  parameter int CH = 16,
  parameter int W  = 16,
  parameter int PW = 8
);
  logic          cfg_we;
  logic [W-1:0]  period_in;
  logic          mode_in;
  logic [PW-1:0] presc_in;
  logic          duty_we;
  logic [CH-1:0] conf;
  logic [W-1:0]  duty_in;
  logic          pol_in;

  modport master (
    output cfg_we, period_in, mode_in, presc_in,
    output duty_we, conf, duty_in, pol_in
  );

  modport slave (
    input cfg_we, period_in, mode_in, presc_in,
    input duty_we, conf, duty_in, pol_in
  );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: one shared prescaled timebase (edge or center aligned),
// double-buffered timebase and per-channel duty/polarity, loaded at period boundaries.

// One PWM channel: duty/polarity shadow + active copy and the registered compare output.
module pwm_lane #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic         wr,
  input  logic [W-1:0] duty_in,
  input  logic         pol_in,
  input  logic         ce,
  input  logic [W-1:0] cnt,
  output logic         out
);
  logic [W-1:0] duty_sh, duty_act;
  logic         pol_sh, pol_act;

  // Shadow capture from the write bus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_sh <= '0;
      pol_sh  <= 1'b0;
    end else if (wr) begin
      duty_sh <= duty_in;
      pol_sh  <= pol_in;
    end
  end

  // Active copy; a write on the boundary clk still loads the old shadow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_act <= '0;
      pol_act  <= 1'b0;
    end else if (ld) begin
      duty_act <= duty_sh;
      pol_act  <= pol_sh;
    end
  end

  // Registered compare; disabled channel sits at its inactive (polarity) level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out <= 1'b0;
    else        out <= (ce & (cnt < duty_act)) ^ pol_act;
  end
endmodule

module pwm_bank #(
  parameter int CH = 16,
  parameter int W  = 16,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  pwm_bank_if.slave     bus,
  input  logic [CH-1:0] ce,
  output logic [CH-1:0] out,
  output logic          sync
);
  localparam logic [W-1:0]  ONE  = W'(1);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic [W-1:0]  per_sh, per_act, cnt;
  logic [PW-1:0] presc_sh, presc_act, pcnt;
  logic          mode_sh, mode_act;
  logic          dir;   // 0 = up, 1 = down (center mode only)
  logic          tick, bnd;
  logic [CH-1:0] wr;

  assign tick = (pcnt == presc_act);
  assign wr   = {CH{bus.duty_we}} & bus.conf;

  // Boundary detect: end of edge period, last down-step in center mode, or any tick at period 0.
  always_comb begin
    bnd = 1'b0;
    if (tick) begin
      if (per_act == '0)  bnd = 1'b1;
      else if (!mode_act) bnd = (cnt == per_act);
      else                bnd = dir & (cnt == ONE);
    end
  end

  // Timebase shadow registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_sh   <= '0;
      mode_sh  <= 1'b0;
      presc_sh <= '0;
    end else if (bus.cfg_we) begin
      per_sh   <= bus.period_in;
      mode_sh  <= bus.mode_in;
      presc_sh <= bus.presc_in;
    end
  end

  // Shared timebase: prescaler, counter, direction; boundary reloads and restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_act   <= '0;
      mode_act  <= 1'b0;
      presc_act <= '0;
      pcnt      <= '0;
      cnt       <= '0;
      dir       <= 1'b0;
    end else if (bnd) begin
      per_act   <= per_sh;
      mode_act  <= mode_sh;
      presc_act <= presc_sh;
      pcnt      <= '0;
      cnt       <= '0;
      dir       <= 1'b0;
    end else if (tick) begin
      pcnt <= '0;
      if (!mode_act) begin
        cnt <= cnt + ONE;
      end else if (!dir) begin
        cnt <= cnt + ONE;
        if (cnt + ONE == per_act) dir <= 1'b1;
      end else begin
        cnt <= cnt - ONE;
        if (cnt == ONE) dir <= 1'b0;
      end
    end else begin
      pcnt <= pcnt + PONE;
    end
  end

  // Boundary strobe, registered alongside the channel outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 1'b0;
    else        sync <= bnd;
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    pwm_lane #(.W(W)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .ld      (bnd),
      .wr      (wr[i]),
      .duty_in (bus.duty_in),
      .pol_in  (bus.pol_in),
      .ce      (ce[i]),
      .cnt     (cnt),
      .out     (out[i])
    );
  end
endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: edge/center timing, duty extremes, polarity/enable,
// write/boundary collision, conf masking and asynchronous reset.
module tb_pwm_bank;
  localparam int CH = 16;
  localparam int W  = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] ce;
  logic [CH-1:0] out;
  logic          sync;

  pwm_bank_if #(.CH(CH), .W(W), .PW(PW)) bus ();

  pwm_bank #(.CH(CH), .W(W), .PW(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .ce    (ce),
    .out   (out),
    .sync  (sync)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [CH-1:0] smp [32];
  logic [31:0]   sv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input logic [W-1:0] per, input logic mode, input logic [PW-1:0] presc);
    bus.cfg_we = 1'b1; bus.period_in = per; bus.mode_in = mode; bus.presc_in = presc;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic duty_wr(input logic [CH-1:0] msk, input logic [W-1:0] d, input logic p);
    bus.duty_we = 1'b1; bus.conf = msk; bus.duty_in = d; bus.pol_in = p;
    @(negedge clk);
    bus.duty_we = 1'b0;
  endtask

  // Advance at least one negedge, then wait (bounded) for the boundary strobe.
  task automatic wait_sync(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!sync && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(sync), 32'd1);
  endtask

  task automatic capture(input int n);
    sv = '0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      smp[j] = out;
      sv = {sv[30:0], sync};
    end
  endtask

  // First captured sample lands in the MSB of the n-bit result.
  function automatic logic [31:0] chan(input int c, input int n);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < n; j++) v = {v[30:0], smp[j][c]};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] or_v, and_v;
    reset = 1'b0; ce = '1;
    bus.cfg_we = 1'b0; bus.period_in = '0; bus.mode_in = 1'b0; bus.presc_in = '0;
    bus.duty_we = 1'b0; bus.conf = '0; bus.duty_in = '0; bus.pol_in = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_sync", 32'(sync), 32'd0);

    // 1: edge, presc 0, period 9, duty 3 on ch0 (written right at reset release)
    reset = 1'b1;
    bus.cfg_we = 1'b1; bus.period_in = 9; bus.mode_in = 1'b0; bus.presc_in = 0;
    bus.duty_we = 1'b1; bus.conf = 16'h0001; bus.duty_in = 3; bus.pol_in = 1'b0;
    @(negedge clk);
    bus.cfg_we = 1'b0; bus.duty_we = 1'b0;
    wait_sync("t1_sync");
    capture(10);
    chk("t1_out0", chan(0, 10), 32'b1110000000);
    chk("t1_sync_v", sv, 32'b0000000001);

    // 2: center, presc 1, period 4, duty 2
    cfg_wr(4, 1'b1, 1);
    duty_wr(16'h0001, 2, 1'b0);
    wait_sync("t2_sync");
    capture(16);
    chk("t2_out0", chan(0, 16), 32'b1111000000000011);
    chk("t2_sync_v", sv, 32'h0001);

    // 3: duty extremes, polarity, enable
    cfg_wr(9, 1'b0, 0);
    duty_wr(16'h0001, 0, 1'b0);
    duty_wr(16'h0002, 10, 1'b0);
    duty_wr(16'h0004, 0, 1'b1);
    duty_wr(16'h0008, 10, 1'b1);
    duty_wr(16'h0010, 3, 1'b0);
    duty_wr(16'h0020, 3, 1'b1);
    ce = 16'hFFCF;
    wait_sync("t3_sync");
    capture(10);
    or_v = '0; and_v = '1;
    for (int j = 0; j < 10; j++) begin
      or_v  = or_v  | smp[j][5:0];
      and_v = and_v & smp[j][5:0];
    end
    chk("t3_or", 32'(or_v), 32'b100110);
    chk("t3_and", 32'(and_v), 32'b100110);

    // 4: duty 7 one clk before a boundary, duty 2 on the boundary clk
    repeat (8) @(negedge clk);
    bus.duty_we = 1'b1; bus.conf = 16'h0001; bus.duty_in = 7; bus.pol_in = 1'b0;
    @(negedge clk);
    bus.duty_in = 2;
    @(negedge clk);
    bus.duty_we = 1'b0;
    chk("t4_bnd", 32'(sync), 32'd1);
    capture(10);
    chk("t4_per7", chan(0, 10), 32'b1111111000);
    capture(10);
    chk("t4_per2", chan(0, 10), 32'b1100000000);

    // 5: conf = 0 is ignored; conf = 0x0005 updates ch0 and ch2 only
    duty_wr(16'h0000, 9, 1'b0);
    wait_sync("t5a_sync");
    capture(10);
    chk("t5a_ch0", chan(0, 10), 32'b1100000000);
    chk("t5a_ch1", chan(1, 10), 32'h3FF);
    duty_wr(16'h0005, 5, 1'b0);
    wait_sync("t5b_sync");
    capture(10);
    chk("t5b_ch0", chan(0, 10), 32'b1111100000);
    chk("t5b_ch1", chan(1, 10), 32'h3FF);
    chk("t5b_ch2", chan(2, 10), 32'b1111100000);

    // 6: asynchronous reset between edges
    @(posedge clk);
    #3;
    chk("t6_pre", 32'(out[1]), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_out", 32'(out), 32'd0);
    chk("t6_sync", 32'(sync), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_first_bnd", 32'(sync), 32'd1);
    @(negedge clk);
    chk("t6_per0_bnd", 32'(sync), 32'd1);
    chk("t6_out_post", 32'(out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
